// File: rtl/des_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : des_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one DES core between two
//            requesters, with completion timeout and per-requester response.
// Revision : 1.0
// ============================================================================
module des_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_mode,
    input  logic [1:64] req0_data,
    input  logic [1:64] req0_key,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_mode,
    input  logic [1:64] req1_data,
    input  logic [1:64] req1_key,

    output logic        rsp0_valid,
    output logic [1:64] rsp0_data,
    output logic        rsp0_err,
    input  logic        rsp0_ack,

    output logic        rsp1_valid,
    output logic [1:64] rsp1_data,
    output logic        rsp1_err,
    input  logic        rsp1_ack,

    output logic        des_enable,
    output logic        des_mode,
    output logic [1:64] des_data_i,
    output logic [1:64] des_key_i,
    input  logic [1:64] des_data_o,
    input  logic        des_ready_o,

    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [1:64]      r_res_data;
    logic             r_res_err;
    logic             r_rsp_valid;

    logic w_both;
    logic w_grant;
    logic w_idle;
    logic w_any;
    logic w_ack;

    // Tie goes to the requester that was not served last.
    always_comb begin
        w_both  = req0_valid & req1_valid;
        w_any   = req0_valid | req1_valid;
        w_grant = w_both ? ~r_last_grant : req1_valid;
        w_idle  = (r_state == IDLE);
        w_ack   = grant_id ? rsp1_ack : rsp0_ack;
    end

    // Ready is masked while reset is held so every output reads zero.
    assign req0_ready = reset & w_idle & req0_valid & ~w_grant;
    assign req1_ready = reset & w_idle & req1_valid &  w_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            grant_id     <= 1'b0;
            r_cnt        <= '0;
            r_res_data   <= '0;
            r_res_err    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            des_enable   <= 1'b0;
            des_mode     <= 1'b0;
            des_data_i   <= '0;
            des_key_i    <= '0;
        end else begin
            des_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        des_mode     <= w_grant ? req1_mode : req0_mode;
                        des_data_i   <= w_grant ? req1_data : req0_data;
                        des_key_i    <= w_grant ? req1_key  : req0_key;
                        grant_id     <= w_grant;
                        r_last_grant <= w_grant;
                        des_enable   <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A done flag in the final counted cycle still wins.
                    if (des_ready_o) begin
                        r_res_data  <= des_data_o;
                        r_res_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_res_data  <= '0;
                        r_res_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (w_ack) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // One shared result register, steered to the owner of the job.
    assign rsp0_valid = r_rsp_valid & ~grant_id;
    assign rsp1_valid = r_rsp_valid &  grant_id;
    assign rsp0_data  = rsp0_valid ? r_res_data : '0;
    assign rsp1_data  = rsp1_valid ? r_res_data : '0;
    assign rsp0_err   = rsp0_valid & r_res_err;
    assign rsp1_err   = rsp1_valid & r_res_err;

    assign busy = ~w_idle;

endmodule
`default_nettype wire
